// File: rtl/cmd_pkg.sv
// Shared opcodes, error codes and FSM encoding for the command frame decoder.
// Frame length depends on CMD_FRAME_CHECKSUM_EN (adds a trailing XOR byte).
package cmd_pkg;

  localparam logic [5:0] OP_INIT  = 6'h00;
  localparam logic [5:0] OP_WRITE = 6'h01;
  localparam logic [5:0] OP_READ  = 6'h02;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_OPCODE  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_WAIT_RD = 2'd3
  } state_t;

  function automatic int frame_len(input int addr_bytes);
`ifdef CMD_FRAME_CHECKSUM_EN
    return addr_bytes + 3;
`else
    return addr_bytes + 2;
`endif
  endfunction

endpackage

// File: rtl/byte_toggle_detect.sv
// Flags a new byte whenever the toggle flag differs from its value last cycle.
// The history register tracks the flag during reset too, so release is silent.
module byte_toggle_detect (
  input  logic clk,
  input  logic reset,
  input  logic byte_finished,
  output logic new_byte
);

  logic prev_finished;

  always_ff @(posedge clk) begin
    prev_finished <= byte_finished;
  end

  assign new_byte = !reset && (byte_finished ^ prev_finished);

endmodule

// File: rtl/cmd_frame_decoder.sv
// Assembles opcode/address/data frames from a toggled byte stream, issues one bus
// command per frame and stages a response byte. Optional: CMD_FRAME_CHECKSUM_EN.
module cmd_frame_decoder
  import cmd_pkg::*;
#(
  parameter int         ADDR_BYTES     = 2,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [7:0] ACK_BYTE       = 8'hA5,
  parameter logic [7:0] ERR_BYTE       = 8'hEE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              in_byte,
  input  logic                    byte_finished,
  output logic [7:0]              out_byte,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [5:0]              cmd_op,
  output logic [8*ADDR_BYTES-1:0] cmd_addr,
  output logic [7:0]              cmd_data,
  input  logic                    rd_valid,
  input  logic [7:0]              rd_data,
  output logic                    busy,
  output logic                    err_pulse,
  output logic [1:0]              err_code
);

  localparam int AW        = 8 * ADDR_BYTES;
  localparam int FRAME_LEN = frame_len(ADDR_BYTES);
  localparam int TW        = $clog2(TIMEOUT_CYCLES);

  localparam logic [3:0]    LAST_IDX = 4'(FRAME_LEN - 1);
  localparam logic [3:0]    ADDR_END = 4'(ADDR_BYTES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic new_byte;

  state_t        state_reg, state_next;
  logic [5:0]    opcode_reg, opcode_next;
  logic [3:0]    byte_idx_reg, byte_idx_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [AW-1:0] addr_shift;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic [7:0]    out_byte_reg, out_byte_next;
  logic          cmd_valid_reg, cmd_valid_next;
  logic [5:0]    cmd_op_reg, cmd_op_next;
  logic [AW-1:0] cmd_addr_reg, cmd_addr_next;
  logic [7:0]    cmd_data_reg, cmd_data_next;
  logic          err_pulse_reg, err_pulse_next;
  logic [1:0]    err_code_reg, err_code_next;
  logic [7:0]    final_data;
  logic          csum_bad;

  byte_toggle_detect u_toggle (
    .clk           (clk),
    .reset         (reset),
    .byte_finished (byte_finished),
    .new_byte      (new_byte)
  );

  // Address bytes arrive MSB first, so each one shifts in from the bottom.
  generate
    if (ADDR_BYTES == 1) begin : g_addr_one
      assign addr_shift = in_byte;
    end else begin : g_addr_many
      assign addr_shift = {addr_reg[AW-9:0], in_byte};
    end
  endgenerate

`ifdef CMD_FRAME_CHECKSUM_EN
  localparam logic [3:0] DATA_IDX = 4'(ADDR_BYTES + 1);

  logic [7:0] data_reg, data_next;
  logic [7:0] csum_reg, csum_next;

  // The data byte is no longer last, so hold it until the checksum arrives.
  always_comb begin
    data_next = data_reg;
    csum_next = csum_reg;
    if (new_byte) begin
      if (state_reg == ST_IDLE) begin
        csum_next = in_byte;
      end else if (state_reg == ST_COLLECT) begin
        csum_next = csum_reg ^ in_byte;
        if (byte_idx_reg == DATA_IDX) data_next = in_byte;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= 8'h00;
      csum_reg <= 8'h00;
    end else begin
      data_reg <= data_next;
      csum_reg <= csum_next;
    end
  end

  assign final_data = data_reg;
  assign csum_bad   = (in_byte != csum_reg);
`else
  assign final_data = in_byte;
  assign csum_bad   = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    opcode_next    = opcode_reg;
    byte_idx_next  = byte_idx_reg;
    addr_next      = addr_reg;
    tmo_next       = tmo_reg;
    out_byte_next  = out_byte_reg;
    cmd_valid_next = cmd_valid_reg;
    cmd_op_next    = cmd_op_reg;
    cmd_addr_next  = cmd_addr_reg;
    cmd_data_next  = cmd_data_reg;
    err_pulse_next = 1'b0;
    err_code_next  = err_code_reg;

    case (state_reg)
      ST_IDLE: begin
        tmo_next = '0;
        if (new_byte) begin
          opcode_next   = in_byte[7:2];
          byte_idx_next = 4'd1;
          addr_next     = '0;
          state_next    = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        // A byte landing on the expiry cycle still counts; the timer just restarts.
        if (new_byte) begin
          tmo_next      = '0;
          byte_idx_next = byte_idx_reg + 4'd1;
          if (byte_idx_reg <= ADDR_END) addr_next = addr_shift;
          if (byte_idx_reg == LAST_IDX) begin
            if ((opcode_reg > OP_READ) || csum_bad) begin
              err_pulse_next = 1'b1;
              err_code_next  = ERR_OPCODE;
              out_byte_next  = ERR_BYTE;
              state_next     = ST_IDLE;
            end else begin
              cmd_valid_next = 1'b1;
              cmd_op_next    = opcode_reg;
              cmd_addr_next  = addr_reg;
              cmd_data_next  = (opcode_reg == OP_WRITE) ? final_data : 8'h00;
              state_next     = ST_ISSUE;
            end
          end
        end else if (tmo_reg == TMO_LAST) begin
          tmo_next       = '0;
          err_pulse_next = 1'b1;
          err_code_next  = ERR_TIMEOUT;
          out_byte_next  = ERR_BYTE;
          state_next     = ST_IDLE;
        end else begin
          tmo_next = tmo_reg + TW'(1);
        end
      end

      ST_ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_next = 1'b0;
          if (cmd_op_reg == OP_READ) begin
            state_next = ST_WAIT_RD;
          end else begin
            out_byte_next = ACK_BYTE;
            state_next    = ST_IDLE;
          end
        end
      end

      ST_WAIT_RD: begin
        if (rd_valid) begin
          out_byte_next = rd_data;
          state_next    = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase

    // Bytes arriving while a command is in flight are dropped, not queued.
    if (new_byte && (state_reg == ST_ISSUE || state_reg == ST_WAIT_RD)) begin
      err_pulse_next = 1'b1;
      err_code_next  = ERR_OVERRUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      opcode_reg    <= 6'h00;
      byte_idx_reg  <= 4'd0;
      addr_reg      <= '0;
      tmo_reg       <= '0;
      out_byte_reg  <= 8'h00;
      cmd_valid_reg <= 1'b0;
      cmd_op_reg    <= 6'h00;
      cmd_addr_reg  <= '0;
      cmd_data_reg  <= 8'h00;
      err_pulse_reg <= 1'b0;
      err_code_reg  <= ERR_NONE;
    end else begin
      state_reg     <= state_next;
      opcode_reg    <= opcode_next;
      byte_idx_reg  <= byte_idx_next;
      addr_reg      <= addr_next;
      tmo_reg       <= tmo_next;
      out_byte_reg  <= out_byte_next;
      cmd_valid_reg <= cmd_valid_next;
      cmd_op_reg    <= cmd_op_next;
      cmd_addr_reg  <= cmd_addr_next;
      cmd_data_reg  <= cmd_data_next;
      err_pulse_reg <= err_pulse_next;
      err_code_reg  <= err_code_next;
    end
  end

  assign out_byte  = out_byte_reg;
  assign cmd_valid = cmd_valid_reg;
  assign cmd_op    = cmd_op_reg;
  assign cmd_addr  = cmd_addr_reg;
  assign cmd_data  = cmd_data_reg;
  assign err_pulse = err_pulse_reg;
  assign err_code  = err_code_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Bench for cmd_frame_decoder: vector table plus hand sequences, with command and
// error scoreboards. Appends the XOR byte when CMD_FRAME_CHECKSUM_EN is defined.
module tb_cmd_frame_decoder;
  import cmd_pkg::*;

  localparam int AB  = 2;
  localparam int TMO = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_byte = 8'h00;
  logic        byte_finished = 1'b0;
  logic [7:0]  out_byte;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [5:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        rd_valid = 1'b0;
  logic [7:0]  rd_data = 8'h00;
  logic        busy;
  logic        err_pulse;
  logic [1:0]  err_code;

  cmd_frame_decoder #(.ADDR_BYTES(AB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .in_byte(in_byte), .byte_finished(byte_finished),
    .out_byte(out_byte), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
    .err_pulse(err_pulse), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [15:0] addr;
    logic [7:0]  data;
  } cmd_t;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    bit          is_err;
    logic [5:0]  op;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  rd;
    logic [7:0]  out;
  } vec_t;

  cmd_t       cmd_q[$];
  logic [1:0] err_q[$];
  vec_t       vecs[8];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Scoreboards: commands compared on acceptance, error codes on each pulse.
  always @(negedge clk) begin
    cmd_t       ec;
    logic [1:0] ee;
    if (!reset) begin
      if (cmd_valid && cmd_ready) begin
        $display("cmd accepted: op=%0d addr=%h data=%h", cmd_op, cmd_addr, cmd_data);
        if (cmd_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_cmd: got op %0d addr %h, required no command", cmd_op, cmd_addr);
        end else begin
          ec = cmd_q.pop_front();
          check("cmd_op", 32'(cmd_op), 32'(ec.op));
          check("cmd_addr", 32'(cmd_addr), 32'(ec.addr));
          check("cmd_data", 32'(cmd_data), 32'(ec.data));
        end
      end
      if (err_pulse) begin
        $display("error pulse: code=%0d", err_code);
        if (err_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_err: got code %0d, required no error", err_code);
        end else begin
          ee = err_q.pop_front();
          check("err_code", 32'(err_code), 32'(ee));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    in_byte = b;
    byte_finished = ~byte_finished;
  endtask

  task automatic send_tail(input logic [7:0] cs, input bit bad_cs);
`ifdef CMD_FRAME_CHECKSUM_EN
    send_byte(bad_cs ? (cs ^ 8'h01) : cs);
`endif
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3, input bit bad_cs);
    send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3);
    send_tail(b0 ^ b1 ^ b2 ^ b3, bad_cs);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic pulse_rd(input logic [7:0] d);
    @(posedge clk); #1;
    rd_valid = 1'b1; rd_data = d;
    @(posedge clk); #1;
    rd_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    bit  fired;

    vecs[0] = '{8'h04, 8'h12, 8'h34, 8'h5A, 1'b0, 6'd1, 16'h1234, 8'h5A, 8'h00, 8'hA5};
    vecs[1] = '{8'h00, 8'hAB, 8'hCD, 8'hEF, 1'b0, 6'd0, 16'hABCD, 8'h00, 8'h00, 8'hA5};
    vecs[2] = '{8'h08, 8'h00, 8'h10, 8'h77, 1'b0, 6'd2, 16'h0010, 8'h00, 8'h3C, 8'h3C};
    vecs[3] = '{8'hFC, 8'h11, 8'h22, 8'h33, 1'b1, 6'd0, 16'h0000, 8'h00, 8'h00, 8'hEE};
    vecs[4] = '{8'h0C, 8'h01, 8'h02, 8'h03, 1'b1, 6'd0, 16'h0000, 8'h00, 8'h00, 8'hEE};
    vecs[5] = '{8'h07, 8'hFF, 8'h00, 8'h01, 1'b0, 6'd1, 16'hFF00, 8'h01, 8'h00, 8'hA5};
    vecs[6] = '{8'h0A, 8'h12, 8'h34, 8'h56, 1'b0, 6'd2, 16'h1234, 8'h00, 8'h99, 8'h99};
    vecs[7] = '{8'h10, 8'h44, 8'h55, 8'h66, 1'b1, 6'd0, 16'h0000, 8'h00, 8'h00, 8'hEE};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_byte", 32'(out_byte), 32'h00);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd_op", 32'(cmd_op), 32'd0);
    check("rst_cmd_addr", 32'(cmd_addr), 32'd0);
    check("rst_cmd_data", 32'(cmd_data), 32'd0);
    check("rst_err", 32'({err_pulse, err_code}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Table-driven frames with cmd_ready held high
    cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_err) err_q.push_back(ERR_OPCODE);
      else cmd_q.push_back({vecs[i].op, vecs[i].addr, vecs[i].data});
      send_frame(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3, 1'b0);
      if (!vecs[i].is_err && vecs[i].op == OP_READ) begin
        repeat (2) @(posedge clk);
        pulse_rd(vecs[i].rd);
      end
      wait_idle("vec_idle");
      check("vec_out_byte", 32'(out_byte), 32'(vecs[i].out));
      if (vecs[i].is_err) check("vec_err_code", 32'(err_code), 32'(ERR_OPCODE));
      $display("vector %0d: frame %h %h %h %h -> out_byte %h", i,
               vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3, out_byte);
    end

    // READ with delayed cmd_ready: command must hold steady while waiting
    cmd_ready = 1'b0;
    cmd_q.push_back({6'd2, 16'h0010, 8'h00});
    send_frame(8'h08, 8'h00, 8'h10, 8'h00, 1'b0);
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("hold_valid", 32'(cmd_valid), 32'd1);
      check("hold_op", 32'(cmd_op), 32'd2);
      check("hold_addr", 32'(cmd_addr), 32'h0010);
      check("hold_data", 32'(cmd_data), 32'h00);
    end
    @(posedge clk); #1;
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    @(negedge clk);
    check("valid_dropped", 32'(cmd_valid), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    rd_valid = 1'b1; rd_data = 8'h3C;
    @(negedge clk);
    check("rd_busy_before", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rd_valid = 1'b0;
    @(negedge clk);
    check("rd_busy_after", 32'(busy), 32'd0);
    check("rd_out_byte", 32'(out_byte), 32'h3C);
    $display("delayed read: out_byte %h", out_byte);

    // Timeout after two bytes, then a clean INIT frame
    cmd_ready = 1'b1;
    send_byte(8'h04);
    send_byte(8'h12);
    err_q.push_back(ERR_TIMEOUT);
    fired = 1'b0;
    k = 0;
    while (!fired && k < 3 * TMO) begin
      @(negedge clk);
      fired = err_pulse;
      k++;
    end
    check("tmo_fired", 32'(fired), 32'd1);
    @(negedge clk);
    check("tmo_err_code", 32'(err_code), 32'(ERR_TIMEOUT));
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_out_byte", 32'(out_byte), 32'hEE);
    cmd_q.push_back({6'd0, 16'h0000, 8'h00});
    send_frame(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    wait_idle("init_idle");
    check("init_out_byte", 32'(out_byte), 32'hA5);
    $display("timeout then INIT: out_byte %h", out_byte);

    // Byte arriving on the exact expiry cycle keeps the frame alive
    cmd_q.push_back({6'd1, 16'h5678, 8'h9A});
    send_byte(8'h04);
    repeat (TMO - 1) @(posedge clk);
    send_byte(8'h56);
    send_byte(8'h78);
    send_byte(8'h9A);
    send_tail(8'h04 ^ 8'h56 ^ 8'h78 ^ 8'h9A, 1'b0);
    wait_idle("edge_idle");
    check("edge_out_byte", 32'(out_byte), 32'hA5);
    $display("byte at expiry: out_byte %h", out_byte);

    // Overrun while waiting for read data
    cmd_q.push_back({6'd2, 16'h0020, 8'h00});
    send_frame(8'h08, 8'h00, 8'h20, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    err_q.push_back(ERR_OVERRUN);
    send_byte(8'h55);
    repeat (2) @(negedge clk);
    check("ovr_err_code", 32'(err_code), 32'(ERR_OVERRUN));
    check("ovr_busy", 32'(busy), 32'd1);
    pulse_rd(8'h42);
    @(negedge clk);
    check("ovr_out_byte", 32'(out_byte), 32'h42);
    check("ovr_busy_after", 32'(busy), 32'd0);
    $display("overrun read: out_byte %h", out_byte);

    // Reset mid-frame with byte_finished high
    send_byte(8'h04);
    send_byte(8'h12);
    @(posedge clk); #1;
    reset = 1'b1;
    if (!byte_finished) byte_finished = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out", 32'(out_byte), 32'h00);
    check("mid_rst_err", 32'(err_code), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    cmd_q.push_back({6'd1, 16'hAABB, 8'hCC});
    send_frame(8'h04, 8'hAA, 8'hBB, 8'hCC, 1'b0);
    wait_idle("post_rst_idle");
    check("post_rst_out", 32'(out_byte), 32'hA5);
    $display("after reset: out_byte %h", out_byte);

    // rd_valid outside WAIT_RD is ignored
    pulse_rd(8'h77);
    @(negedge clk);
    check("stray_rd_out", 32'(out_byte), 32'hA5);
    check("stray_rd_busy", 32'(busy), 32'd0);

`ifdef CMD_FRAME_CHECKSUM_EN
    err_q.push_back(ERR_OPCODE);
    send_frame(8'h04, 8'h11, 8'h22, 8'h33, 1'b1);
    wait_idle("cs_idle");
    check("cs_out_byte", 32'(out_byte), 32'hEE);
    check("cs_err_code", 32'(err_code), 32'(ERR_OPCODE));
    $display("bad checksum: out_byte %h", out_byte);
`endif

    repeat (3) @(negedge clk);
    check("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
    check("err_q_drained", 32'(err_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
